// File: rtl/placar_pkg.sv
// ============================================================================
// Module  : placar_pkg
// Purpose : Widths, 7-segment digit patterns and the digit encoder shared
//           by the truco scoreboard datapath.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package placar_pkg;

    localparam int PONTOS_W = 4;
    localparam int TENTOS_W = 2;

    // Patterns are stored active-low, bit order gfedcba
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    function automatic logic [6:0] seg7_encode(input logic [3:0] value,
                                               input logic       active_low);
        logic [6:0] pat;
        case (value)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_DASH;
        endcase
        return active_low ? pat : ~pat;
    endfunction

    function automatic logic [6:0] seg7_blank(input logic active_low);
        return active_low ? SEG_BLANK : ~SEG_BLANK;
    endfunction

endpackage

`default_nettype wire

// File: rtl/placar_datapath_if.sv
// ============================================================================
// Module  : placar_datapath_if
// Purpose : Strobes from the scoreboard controller and the register, flag
//           and display outputs returned by the datapath.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface placar_datapath_if;
    import placar_pkg::*;

    logic                load_pa, load_pb, clear_pa, clear_pb;
    logic                load_ta, load_tb, clear_ta, clear_tb;
    logic                a_igual12, b_igual12, ta_igual3, tb_igual3;
    logic [PONTOS_W-1:0] pa, pb;
    logic [TENTOS_W-1:0] ta, tb;
    logic [6:0]          hex_pa_d, hex_pa_u, hex_pb_d, hex_pb_u;
    logic [6:0]          hex_ta, hex_tb;

    modport master (
        output load_pa, load_pb, clear_pa, clear_pb,
        output load_ta, load_tb, clear_ta, clear_tb,
        input  a_igual12, b_igual12, ta_igual3, tb_igual3,
        input  pa, pb, ta, tb,
        input  hex_pa_d, hex_pa_u, hex_pb_d, hex_pb_u, hex_ta, hex_tb
    );

    modport slave (
        input  load_pa, load_pb, clear_pa, clear_pb,
        input  load_ta, load_tb, clear_ta, clear_tb,
        output a_igual12, b_igual12, ta_igual3, tb_igual3,
        output pa, pb, ta, tb,
        output hex_pa_d, hex_pa_u, hex_pb_d, hex_pb_u, hex_ta, hex_tb
    );

endinterface

`default_nettype wire

// File: rtl/contador_sat.sv
// ============================================================================
// Module  : contador_sat
// Purpose : Saturating up-counter with clear priority and an at-max flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module contador_sat #(
    parameter int WIDTH = 4,
    parameter int MAX   = 12
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             load,
    input  wire logic             clear,
    output logic      [WIDTH-1:0] q,
    output logic                  eq_max
);

    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAX);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load && (cnt_q != C_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q      = cnt_q;
    assign eq_max = (cnt_q == C_MAX);

endmodule

`default_nettype wire

// File: rtl/placar_datapath.sv
// ============================================================================
// Module  : placar_datapath
// Purpose : Four saturating game counters, their equality flags and six
//           registered 7-segment digits for the scoreboard display.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module placar_datapath
    import placar_pkg::*;
#(
    parameter int PONTOS_MAX     = 12,
    parameter int TENTOS_MAX     = 3,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  wire logic          clk,
    input  wire logic          reset,
    placar_datapath_if.slave   bus
);

    localparam logic [6:0] C_SEG_ZERO  = seg7_encode(4'd0, SEG_ACTIVE_LOW);
    localparam logic [6:0] C_SEG_ONE   = seg7_encode(4'd1, SEG_ACTIVE_LOW);
    localparam logic [6:0] C_SEG_BLANK = seg7_blank(SEG_ACTIVE_LOW);

    contador_sat #(.WIDTH(PONTOS_W), .MAX(PONTOS_MAX)) u_pa (
        .clk(clk), .reset(reset), .load(bus.load_pa), .clear(bus.clear_pa),
        .q(bus.pa), .eq_max(bus.a_igual12));

    contador_sat #(.WIDTH(PONTOS_W), .MAX(PONTOS_MAX)) u_pb (
        .clk(clk), .reset(reset), .load(bus.load_pb), .clear(bus.clear_pb),
        .q(bus.pb), .eq_max(bus.b_igual12));

    contador_sat #(.WIDTH(TENTOS_W), .MAX(TENTOS_MAX)) u_ta (
        .clk(clk), .reset(reset), .load(bus.load_ta), .clear(bus.clear_ta),
        .q(bus.ta), .eq_max(bus.ta_igual3));

    contador_sat #(.WIDTH(TENTOS_W), .MAX(TENTOS_MAX)) u_tb (
        .clk(clk), .reset(reset), .load(bus.load_tb), .clear(bus.clear_tb),
        .q(bus.tb), .eq_max(bus.tb_igual3));

    logic [6:0] pa_tens_q, pa_tens_d, pa_units_q, pa_units_d;
    logic [6:0] pb_tens_q, pb_tens_d, pb_units_q, pb_units_d;
    logic [6:0] ta_seg_q, ta_seg_d, tb_seg_q, tb_seg_d;

    // Points never exceed 12, so a single subtraction gives value % 10
    always_comb begin
        pa_tens_d  = (bus.pa >= 4'd10) ? C_SEG_ONE : C_SEG_BLANK;
        pa_units_d = seg7_encode((bus.pa >= 4'd10) ? bus.pa - 4'd10 : bus.pa,
                                 SEG_ACTIVE_LOW);
        pb_tens_d  = (bus.pb >= 4'd10) ? C_SEG_ONE : C_SEG_BLANK;
        pb_units_d = seg7_encode((bus.pb >= 4'd10) ? bus.pb - 4'd10 : bus.pb,
                                 SEG_ACTIVE_LOW);
        ta_seg_d   = seg7_encode({2'b00, bus.ta}, SEG_ACTIVE_LOW);
        tb_seg_d   = seg7_encode({2'b00, bus.tb}, SEG_ACTIVE_LOW);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pa_tens_q  <= C_SEG_BLANK;
            pa_units_q <= C_SEG_ZERO;
            pb_tens_q  <= C_SEG_BLANK;
            pb_units_q <= C_SEG_ZERO;
            ta_seg_q   <= C_SEG_ZERO;
            tb_seg_q   <= C_SEG_ZERO;
        end else begin
            pa_tens_q  <= pa_tens_d;
            pa_units_q <= pa_units_d;
            pb_tens_q  <= pb_tens_d;
            pb_units_q <= pb_units_d;
            ta_seg_q   <= ta_seg_d;
            tb_seg_q   <= tb_seg_d;
        end
    end

    assign bus.hex_pa_d = pa_tens_q;
    assign bus.hex_pa_u = pa_units_q;
    assign bus.hex_pb_d = pb_tens_q;
    assign bus.hex_pb_u = pb_units_q;
    assign bus.hex_ta   = ta_seg_q;
    assign bus.hex_tb   = tb_seg_q;

endmodule

`default_nettype wire

// File: tb/tb_placar_datapath.sv
// ============================================================================
// Module  : tb_placar_datapath
// Purpose : Directed-vector bench with a score-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_placar_datapath;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 1'b0;

    placar_datapath_if bus();

    placar_datapath #(.PONTOS_MAX(12), .TENTOS_MAX(3), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .reset(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Reference: scores as plain integers, display shows last cycle's scores
    int m_pa, m_pb, m_ta, m_tb;
    int s_pa, s_pb, s_ta, s_tb;

    function automatic int next_score(int v, bit ld, bit cl, int mx);
        if (cl) return 0;
        if (ld) return (v + 1 > mx) ? mx : v + 1;
        return v;
    endfunction

    function automatic logic [6:0] digit(int d);
        logic [6:0] tbl [10];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return tbl[d];
    endfunction

    function automatic logic [6:0] tens(int v);
        return (v >= 10) ? digit(v / 10) : 7'h7F;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pa <= 0; m_pb <= 0; m_ta <= 0; m_tb <= 0;
            s_pa <= 0; s_pb <= 0; s_ta <= 0; s_tb <= 0;
        end else begin
            s_pa <= m_pa; s_pb <= m_pb; s_ta <= m_ta; s_tb <= m_tb;
            m_pa <= next_score(m_pa, bus.load_pa, bus.clear_pa, 12);
            m_pb <= next_score(m_pb, bus.load_pb, bus.clear_pb, 12);
            m_ta <= next_score(m_ta, bus.load_ta, bus.clear_ta, 3);
            m_tb <= next_score(m_tb, bus.load_tb, bus.clear_tb, 3);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("pa", int'(bus.pa), m_pa);
            check("pb", int'(bus.pb), m_pb);
            check("ta", int'(bus.ta), m_ta);
            check("tb", int'(bus.tb), m_tb);
            check("a_igual12", int'(bus.a_igual12), int'(m_pa == 12));
            check("b_igual12", int'(bus.b_igual12), int'(m_pb == 12));
            check("ta_igual3", int'(bus.ta_igual3), int'(m_ta == 3));
            check("tb_igual3", int'(bus.tb_igual3), int'(m_tb == 3));
            check("hex_pa_d", int'(bus.hex_pa_d), int'(tens(s_pa)));
            check("hex_pa_u", int'(bus.hex_pa_u), int'(digit(s_pa % 10)));
            check("hex_pb_d", int'(bus.hex_pb_d), int'(tens(s_pb)));
            check("hex_pb_u", int'(bus.hex_pb_u), int'(digit(s_pb % 10)));
            check("hex_ta", int'(bus.hex_ta), int'(digit(s_ta)));
            check("hex_tb", int'(bus.hex_tb), int'(digit(s_tb)));
        end
    end

    // Strobe order: load_pa clear_pa load_pb clear_pb load_ta clear_ta load_tb clear_tb
    localparam logic [7:0] LPA = 8'h80, CPA = 8'h40, LPB = 8'h20, CPB = 8'h10;
    localparam logic [7:0] LTA = 8'h08, CTA = 8'h04, LTB = 8'h02, CTB = 8'h01;

    task automatic drive(input logic [7:0] s);
        {bus.load_pa, bus.clear_pa, bus.load_pb, bus.clear_pb,
         bus.load_ta, bus.clear_ta, bus.load_tb, bus.clear_tb} = s;
    endtask

    // One cycle of strobes; returns 1 time unit after the capturing edge
    task automatic step(input logic [7:0] s);
        @(negedge clk);
        #1 drive(s);
        @(posedge clk);
        #1 drive(8'h00);
    endtask

    task automatic repeat_step(input logic [7:0] s, input int n);
        for (int i = 0; i < n; i++) step(s);
    endtask

    initial begin
        drive(8'h00);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        cmp_en = 1'b1;

        repeat_step(8'h00, 5);
        check("lit reset pa", int'(bus.pa), 0);
        check("lit reset hex_pa_u", int'(bus.hex_pa_u), 7'h40);
        check("lit reset hex_pa_d", int'(bus.hex_pa_d), 7'h7F);

        repeat_step(LPA, 11);
        check("lit pa after 11", int'(bus.a_igual12), 0);
        step(LPA);
        check("lit pa after 12", int'(bus.pa), 12);
        check("lit a_igual12", int'(bus.a_igual12), 1);
        step(8'h00);
        check("lit hex_pa_d 12", int'(bus.hex_pa_d), 7'h79);
        check("lit hex_pa_u 12", int'(bus.hex_pa_u), 7'h24);
        step(LPA);
        check("lit pa saturated", int'(bus.pa), 12);

        repeat_step(LPB, 5);
        check("lit pb 5", int'(bus.pb), 5);
        step(CPA | CPB | LTA);
        check("lit combo pa", int'(bus.pa), 0);
        check("lit combo pb", int'(bus.pb), 0);
        check("lit combo ta", int'(bus.ta), 1);
        check("lit combo a_igual12", int'(bus.a_igual12), 0);

        repeat_step(LTB, 3);
        check("lit tb 3", int'(bus.tb), 3);
        check("lit tb_igual3", int'(bus.tb_igual3), 1);
        step(LTB);
        check("lit tb saturated", int'(bus.tb), 3);

        repeat_step(LPB, 7);
        check("lit pb 7", int'(bus.pb), 7);
        step(CPB | LPB);
        check("lit clear wins", int'(bus.pb), 0);

        step(CTA | CTB | CPA);
        repeat_step(LPA | LTA, 2);
        repeat_step(LPA, 7);
        repeat_step(8'h00, 2);
        check("lit pa 9", int'(bus.pa), 9);
        check("lit hex_ta 2", int'(bus.hex_ta), 7'h24);

        #2 rst_n = 1'b0;
        #1;
        check("lit async pa", int'(bus.pa), 0);
        check("lit async ta", int'(bus.ta), 0);
        check("lit async hex_pa_u", int'(bus.hex_pa_u), 7'h40);
        check("lit async hex_pa_d", int'(bus.hex_pa_d), 7'h7F);
        check("lit async hex_ta", int'(bus.hex_ta), 7'h40);
        @(negedge clk);
        #2 rst_n = 1'b1;

        repeat_step(LPA | LTB, 3);
        step(8'h00);
        check("lit resume pa", int'(bus.pa), 3);
        check("lit resume hex_pa_u", int'(bus.hex_pa_u), 7'h30);
        repeat_step(8'h00, 2);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: simulation did not finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

endmodule

`default_nettype wire
